round_sequencer: RTL and testbench

//  Synchronous game-flow controller for Ninety-Nine. It sequences each round:

---
 rtl/round_sequencer.sv | 170 +++++++++++++++++
 tb/tb_round_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// ----------------------------------------------------------------------------
// round_sequencer
//   Game-flow controller for Ninety-Nine. It steps each round through
//   IDLE -> GAP -> ARMED and into OVER, drives the countdown timer's load/run
//   controls, chooses the prompted letter and keeps the BCD score and the
//   best (lowest) final score seen since reset.
//
// Ports
//   hz100         in   system clock
//   reset         in   synchronous active-high reset
//   key_valid     in   one-cycle pulse per synchronised key press
//   key_code      in   key identity, 1=A .. 6=F
//   rand_sel      in   free-running value used for the letter choice
//   timer_expired in   countdown timer reached 00
//   timer_load    out  one-cycle pulse: timer loads timer_value
//   timer_value   out  BCD time allowance for the round (tracks score)
//   timer_run     out  timer counts down while high (ARMED)
//   phase         out  0=IDLE 1=GAP 2=ARMED 3=OVER
//   prompt        out  letter to press in ARMED, 0 otherwise
//   score         out  BCD current score
//   best          out  BCD lowest final score since reset
//   new_best      out  one-cycle pulse when best updates
// ----------------------------------------------------------------------------
module round_sequencer #(
    parameter logic [7:0] START_BCD = 8'h99,
    parameter logic [7:0] MIN_BCD   = 8'h05,
    parameter int         GAP_TICKS = 20
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [2:0] key_code,
    input  logic [2:0] rand_sel,
    input  logic       timer_expired,
    output logic       timer_load,
    output logic [7:0] timer_value,
    output logic       timer_run,
    output logic [1:0] phase,
    output logic [2:0] prompt,
    output logic [7:0] score,
    output logic [7:0] best,
    output logic       new_best
);

    localparam int              GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        ARMED = 2'd2,
        OVER  = 2'd3
    } phase_t;

    phase_t          phase_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic [7:0]      score_reg;
    logic [7:0]      best_reg;
    logic [2:0]      prompt_reg;
    logic [2:0]      last_reg;      // letter of the most recent prompt
    logic            load_reg;
    logic            run_reg;
    logic            new_best_reg;

    logic [2:0]      letter_base;
    logic [2:0]      letter_next;
    logic [7:0]      score_dec_next;
    logic            go_over;

    // Out-of-range selector values map to A; a repeat of the previous
    // prompt is bumped to the next letter (F wraps to A).
    always_comb begin
        letter_base = ((rand_sel == 3'd0) || (rand_sel == 3'd7)) ? 3'd1 : rand_sel;
        letter_next = letter_base;
        if (letter_base == last_reg) begin
            letter_next = (letter_base == 3'd6) ? 3'd1 : letter_base + 3'd1;
        end
    end

    // BCD decrement with borrow from the tens digit; held at the floor.
    always_comb begin
        score_dec_next = score_reg;
        if (score_reg != MIN_BCD) begin
            if (score_reg[3:0] == 4'd0) begin
                score_dec_next = {score_reg[7:4] - 4'd1, 4'd9};
            end else begin
                score_dec_next = {score_reg[7:4], score_reg[3:0] - 4'd1};
            end
        end
    end

    // Every way into OVER: early press in GAP, expiry in ARMED (which beats
    // a simultaneous correct key), or a wrong key in ARMED.
    always_comb begin
        go_over = 1'b0;
        if (phase_reg == GAP) begin
            go_over = key_valid;
        end else if (phase_reg == ARMED) begin
            go_over = timer_expired || (key_valid && (key_code != prompt_reg));
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            phase_reg    <= IDLE;
            gap_cnt_reg  <= '0;
            score_reg    <= START_BCD;
            best_reg     <= 8'h99;
            prompt_reg   <= 3'd0;
            last_reg     <= 3'd0;
            load_reg     <= 1'b0;
            run_reg      <= 1'b0;
            new_best_reg <= 1'b0;
        end else begin
            load_reg     <= 1'b0;
            new_best_reg <= 1'b0;
            if (go_over) begin
                phase_reg  <= OVER;
                prompt_reg <= 3'd0;
                run_reg    <= 1'b0;
                // Binary compare orders BCD values correctly.
                if (score_reg < best_reg) begin
                    best_reg     <= score_reg;
                    new_best_reg <= 1'b1;
                end
            end else begin
                case (phase_reg)
                    IDLE, OVER: begin
                        if (key_valid && (key_code == 3'd1)) begin
                            phase_reg   <= GAP;
                            gap_cnt_reg <= GAP_LOAD;
                            score_reg   <= START_BCD;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_reg == '0) begin
                            phase_reg  <= ARMED;
                            prompt_reg <= letter_next;
                            last_reg   <= letter_next;
                            load_reg   <= 1'b1;
                            run_reg    <= 1'b1;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                    end
                    ARMED: begin
                        // go_over is clear here, so any key is the correct one.
                        if (key_valid) begin
                            phase_reg   <= GAP;
                            gap_cnt_reg <= GAP_LOAD;
                            score_reg   <= score_dec_next;
                            prompt_reg  <= 3'd0;
                            run_reg     <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign phase       = phase_reg;
    assign prompt      = prompt_reg;
    assign score       = score_reg;
    assign best        = best_reg;
    assign timer_load  = load_reg;
    assign timer_run   = run_reg;
    assign timer_value = score_reg;
    assign new_best    = new_best_reg;

endmodule

// File: tb/tb_round_sequencer.sv
// ----------------------------------------------------------------------------
// tb_round_sequencer
//   Random-stimulus bench for round_sequencer. A behavioural model keeps the
//   score as a decimal integer and the gap as a count of remaining cycles; its
//   state is compared against every DUT output once per clock. The first part
//   of the run plays cautiously (no wrong keys, no expiry) so the score walks
//   down to the floor; the rest mixes in wrong keys, early presses, expiries
//   (some coinciding with a correct key) and random resets.
// ----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam int GAP_TICKS = 20;
    localparam int START_DEC = 99;
    localparam int MIN_DEC   = 5;
    localparam int N_CYCLES  = 10000;
    localparam int CAREFUL   = 4000;

    logic       hz100;
    logic       reset;
    logic       key_valid;
    logic [2:0] key_code;
    logic [2:0] rand_sel;
    logic       timer_expired;
    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_run;
    logic [1:0] phase;
    logic [2:0] prompt;
    logic [7:0] score;
    logic [7:0] best;
    logic       new_best;

    round_sequencer #(
        .START_BCD (8'h99),
        .MIN_BCD   (8'h05),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .hz100         (hz100),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .rand_sel      (rand_sel),
        .timer_expired (timer_expired),
        .timer_load    (timer_load),
        .timer_value   (timer_value),
        .timer_run     (timer_run),
        .phase         (phase),
        .prompt        (prompt),
        .score         (score),
        .best          (best),
        .new_best      (new_best)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference state: phase 0..3, scores as plain decimal integers.
    int m_phase    = 0;
    int m_gap_left = 0;
    int m_score    = START_DEC;
    int m_best     = 99;
    int m_prompt   = 0;
    int m_last     = 0;
    int m_load     = 0;
    int m_run      = 0;
    int m_newbest  = 0;
    int n_games    = 0;

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_over();
        m_phase  = 3;
        m_prompt = 0;
        m_run    = 0;
        if (m_score < m_best) begin
            m_best    = m_score;
            m_newbest = 1;
        end
        n_games++;
        $display("[TB] cycle %0d game %0d over: score=%h best=%h", cyc, n_games,
                 to_bcd(m_score), to_bcd(m_best));
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic model_step();
        int l;
        m_load    = 0;
        m_newbest = 0;
        if (reset) begin
            m_phase  = 0;
            m_score  = START_DEC;
            m_best   = 99;
            m_prompt = 0;
            m_last   = 0;
            m_run    = 0;
        end else begin
            case (m_phase)
                0, 3: begin
                    if (key_valid && key_code == 3'd1) begin
                        m_phase    = 1;
                        m_gap_left = GAP_TICKS;
                        m_score    = START_DEC;
                    end
                end
                1: begin
                    if (key_valid) begin
                        model_over();
                    end else begin
                        m_gap_left--;
                        if (m_gap_left == 0) begin
                            l = (rand_sel >= 1 && rand_sel <= 6) ? int'(rand_sel) : 1;
                            if (l == m_last) l = (l % 6) + 1;
                            m_phase  = 2;
                            m_prompt = l;
                            m_last   = l;
                            m_load   = 1;
                            m_run    = 1;
                        end
                    end
                end
                default: begin
                    if (timer_expired) begin
                        model_over();
                    end else if (key_valid) begin
                        if (int'(key_code) == m_prompt) begin
                            if (m_score > MIN_DEC) m_score = m_score - 1;
                            m_phase    = 1;
                            m_gap_left = GAP_TICKS;
                            m_prompt   = 0;
                            m_run      = 0;
                        end else begin
                            model_over();
                        end
                    end
                end
            endcase
        end
    endtask

    initial begin
        bit careful;
        int r;
        reset         = 1'b1;
        key_valid     = 1'b0;
        key_code      = 3'd0;
        rand_sel      = 3'd0;
        timer_expired = 1'b0;

        for (cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge hz100);
            if (cyc > 0) begin
                check_value("phase",       8'(phase),       8'(m_phase));
                check_value("prompt",      8'(prompt),      8'(m_prompt));
                check_value("score",       score,           to_bcd(m_score));
                check_value("best",        best,            to_bcd(m_best));
                check_value("timer_value", timer_value,     to_bcd(m_score));
                check_value("timer_load",  8'(timer_load),  8'(m_load));
                check_value("timer_run",   8'(timer_run),   8'(m_run));
                check_value("new_best",    8'(new_best),    8'(m_newbest));
            end

            careful       = (cyc < CAREFUL);
            reset         = 1'b0;
            key_valid     = 1'b0;
            key_code      = 3'd0;
            timer_expired = 1'b0;
            rand_sel      = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            r             = $urandom_range(0, 999);

            case (m_phase)
                0, 3: begin
                    if (r < 150) begin
                        key_valid = 1'b1;
                        key_code  = (r < 100) ? 3'd1 : 3'($urandom_range(0, 7));
                    end
                    if ($urandom_range(0, 99) < 3) timer_expired = 1'b1;
                end
                1: begin
                    if (!careful && r < 8) begin
                        key_valid = 1'b1;
                        key_code  = 3'($urandom_range(0, 7));
                    end
                    if ($urandom_range(0, 99) < 3) timer_expired = 1'b1;
                end
                default: begin
                    if (r < 300) begin
                        key_valid = 1'b1;
                        key_code  = 3'(m_prompt);
                    end else if (!careful && r < 330) begin
                        key_valid = 1'b1;
                        key_code  = 3'($urandom_range(0, 7));
                    end
                    if (!careful && $urandom_range(0, 99) < 4) begin
                        timer_expired = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            key_valid = 1'b1;
                            key_code  = 3'(m_prompt);
                        end
                    end
                end
            endcase

            if (cyc < 2) reset = 1'b1;
            else if (!careful && $urandom_range(0, 999) < 3) reset = 1'b1;

            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
